seq_neuron: RTL and testbench

Sequential, parametrised fixed-point neuron computing H = act(sum_i X_i*W_i + B) over M signed Qintbits.fracbits inputs. It uses P parallel multipliers time-multiplexed over M/P cycles, accumulates at full precision, then rounds and saturates once. It adds bias, optional ReLU, an overflow flag, and valid/ready handshakes on input and output. It replaces the purely combinational neuron in layer datapaths where area matters more than single-cycle latency.

---
 rtl/seq_neuron.sv | 143 ++++++++++++++
 tb/tb_seq_neuron.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_neuron.sv
// Sequential fixed-point neuron: H = act(sum X_i*W_i + B) using P multipliers over M/P cycles.
// Full-precision accumulation, then a single floor-shift, saturation and optional ReLU.
module seq_neuron #(
  parameter int M        = 8,
  parameter int n        = 32,
  parameter int intbits  = 12,
  parameter int fracbits = 20,
  parameter int P        = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M*n-1:0] X,
  input  logic [M*n-1:0] W,
  input  logic [n-1:0]   B,
  input  logic           relu_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [n-1:0]   H,
  output logic           ovf
);

  // state | meaning
  // IDLE  | waiting for an operand set (in_ready=1)
  // ACCUM | adding P products per cycle for M/P cycles
  // DONE  | result held until out_ready

  localparam int NCH = M / P;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = 2 * n + $clog2(M + 1) + 1;

  localparam logic signed [AW-1:0] HMAX = {{(AW-n+1){1'b0}}, {(n-1){1'b1}}};
  localparam logic signed [AW-1:0] HMIN = {{(AW-n+1){1'b1}}, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, state_nxt;

  logic [M*n-1:0]         x_r, w_r;
  logic                   relu_r;
  logic signed [AW-1:0]   acc, acc_sum, r;
  logic [CW-1:0]          cnt;
  logic                   last_chunk;
  logic                   accept;
  logic [n-1:0]           h_r, h_nxt;
  logic                   ovf_r, ovf_nxt;
  logic [n-1:0]           xs [P];
  logic [n-1:0]           ws [P];
  logic signed [2*n-1:0]  prod [P];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign last_chunk = (cnt == CW'(NCH - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);
  assign H         = h_r;
  assign ovf       = ovf_r;

  // Operand selection for the current chunk; products are the full 2n-bit signed values.
  always_comb begin
    for (int j = 0; j < P; j++) begin
      xs[j]   = x_r[(int'(cnt) * P + j) * n +: n];
      ws[j]   = w_r[(int'(cnt) * P + j) * n +: n];
      prod[j] = $signed({{n{xs[j][n-1]}}, xs[j]}) * $signed({{n{ws[j][n-1]}}, ws[j]});
    end
  end

  always_comb begin
    acc_sum = acc;
    for (int j = 0; j < P; j++) begin
      acc_sum = acc_sum + $signed({{(AW-2*n){prod[j][2*n-1]}}, prod[j]});
    end
  end

  // Result formed from the sum that includes the final chunk, so DONE shows it immediately.
  always_comb begin
    r       = acc_sum >>> fracbits;
    h_nxt   = r[n-1:0];
    ovf_nxt = 1'b0;
    if (r > HMAX) begin
      h_nxt   = {1'b0, {(n-1){1'b1}}};
      ovf_nxt = 1'b1;
    end else if (r < HMIN) begin
      h_nxt   = {1'b1, {(n-1){1'b0}}};
      ovf_nxt = 1'b1;
    end
    if (relu_r && h_nxt[n-1]) h_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_r    <= '0;
      w_r    <= '0;
      relu_r <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      h_r    <= '0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      x_r    <= X;
      w_r    <= W;
      relu_r <= relu_en;
      acc    <= $signed({{(AW-n){B[n-1]}}, B}) <<< fracbits;
      cnt    <= '0;
    end else if (state == ACCUM) begin
      acc <= acc_sum;
      if (last_chunk) begin
        cnt   <= '0;
        h_r   <= h_nxt;
        ovf_r <= ovf_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_neuron.sv
// Scoreboard bench for seq_neuron: expected results queued at acceptance, compared at out_valid.
module tb_seq_neuron;
  localparam int M = 8, n = 32, intbits = 12, fracbits = 20, P = 2;
  localparam int NCH = M / P;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [M*n-1:0] X = '0;
  logic [M*n-1:0] W = '0;
  logic [n-1:0]   B = '0;
  logic           relu_en = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [n-1:0]   H;
  logic           ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [n:0] sb[$];

  seq_neuron #(.M(M), .n(n), .intbits(intbits), .fracbits(fracbits), .P(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .W(W), .B(B), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .H(H), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [M*n-1:0] fill(input logic [n-1:0] v);
    return {M{v}};
  endfunction

  // Reference: exact wide arithmetic, floor shift, saturate, then ReLU.
  function automatic logic [n:0] model(input logic [M*n-1:0] x, input logic [M*n-1:0] w,
                                       input logic [n-1:0] b, input logic relu);
    logic signed [127:0] acc, r, xi, wi;
    logic signed [n-1:0] bs, xs, ws;
    logic [n-1:0] h;
    logic o;
    bs  = b;
    acc = 128'(bs);
    acc = acc <<< fracbits;
    for (int i = 0; i < M; i++) begin
      xs  = x[i*n +: n];
      ws  = w[i*n +: n];
      xi  = 128'(xs);
      wi  = 128'(ws);
      acc = acc + xi * wi;
    end
    r = acc >>> fracbits;
    o = 1'b0;
    h = r[n-1:0];
    if (r > 128'sh7FFFFFFF) begin
      h = 32'h7FFFFFFF; o = 1'b1;
    end else if (r < -128'sh80000000) begin
      h = 32'h80000000; o = 1'b1;
    end
    if (relu && h[n-1]) h = '0;
    return {o, h};
  endfunction

  task automatic send(input logic [M*n-1:0] x, input logic [M*n-1:0] w,
                      input logic [n-1:0] b, input logic relu, input bit track);
    int g = 0;
    while (!in_ready && g < 50) begin tick(); g++; end
    check("in_ready_idle", in_ready, 1);
    X = x; W = w; B = b; relu_en = relu; in_valid = 1'b1;
    if (track) sb.push_back(model(x, w, b, relu));
    tick();
    in_valid = 1'b0;
    X = {M{$urandom()}};
    W = {M{$urandom()}};
    B = $urandom();
    relu_en = ~relu;
  endtask

  task automatic collect(input int hold);
    int lat = 0;
    logic [n:0] e;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check("latency", lat, NCH);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
      e = '0;
    end else begin
      e = sb.pop_front();
      check("H", H, e[n-1:0]);
      check("ovf", ovf, e[n]);
    end
    for (int k = 0; k < hold; k++) begin
      if (k == 3) begin
        X = fill(32'h00100000); W = fill(32'h00100000); B = '0; in_valid = 1'b1;
      end
      if (k == 5) in_valid = 1'b0;
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_H", H, e[n-1:0]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("ready_back", in_ready, 1);
  endtask

  initial begin
    #1;
    check("rst_in_ready", in_ready, 0);
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_H", H, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);

    send(fill(32'h00100000), fill(32'h00080000), 32'h0, 1'b0, 1'b1);
    collect(0);
    check("basic_H", H, 32'h00400000);

    send(fill(32'h00100000), fill(32'hFFF00000), 32'h0, 1'b0, 1'b1);
    collect(0);
    check("neg_H", H, 32'hFF800000);
    send(fill(32'h00100000), fill(32'hFFF00000), 32'h0, 1'b1, 1'b1);
    collect(0);
    check("relu_H", H, 32'h0);
    check("relu_ovf", ovf, 0);

    send(fill(32'h40000000), fill(32'h01000000), 32'h0, 1'b0, 1'b1);
    collect(0);
    check("satp_H", H, 32'h7FFFFFFF);
    check("satp_ovf", ovf, 1);
    send(fill(32'h40000000), fill(32'hFF000000), 32'h0, 1'b0, 1'b1);
    collect(0);
    check("satn_H", H, 32'h80000000);
    check("satn_ovf", ovf, 1);
    send(fill(32'h40000000), fill(32'hFF000000), 32'h0, 1'b1, 1'b1);
    collect(0);
    check("satn_relu_H", H, 32'h0);
    check("satn_relu_ovf", ovf, 1);

    send(fill(32'h00000001), fill(32'hFFF80000), 32'h0, 1'b0, 1'b1);
    collect(0);
    check("floor_neg_H", H, 32'hFFFFFFFC);
    send(fill(32'h00000001), fill(32'h00080000), 32'h0, 1'b0, 1'b1);
    collect(0);
    check("floor_pos_H", H, 32'h00000004);

    // Backpressure with an ignored in_valid pulse while DONE.
    send('0, fill(32'h12345678), 32'hFFFC0000, 1'b0, 1'b1);
    collect(10);
    check("bias_H", H, 32'hFFFC0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_extra_valid", out_valid, 0);
      check("idle_ready", in_ready, 1);
    end

    // Reset at cnt=2 aborts the operation.
    send(fill(32'h00100000), fill(32'h00100000), 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_H", H, 0);
    check("midrst_ovf", ovf, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_no_valid", out_valid, 0);
    end
    send(fill(32'h00100000), fill(32'h00080000), 32'h00100000, 1'b0, 1'b1);
    collect(0);
    check("after_rst_H", H, 32'h00500000);

    for (int t = 0; t < 6; t++) begin
      logic [M*n-1:0] x, w;
      for (int i = 0; i < M; i++) begin
        x[i*n +: n] = (t < 3) ? n'($signed(16'($urandom()))) <<< 8 : $urandom();
        w[i*n +: n] = (t < 3) ? n'($signed(16'($urandom()))) <<< 6 : $urandom();
      end
      send(x, w, $urandom(), 1'($urandom()), 1'b1);
      collect(t % 2);
    end

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
